// File: rtl/sdram_stream_writer_if.sv
// Byte-stream intake and single-word write port between the SD-card stream
// writer (master) and its byte source / SDRAM arbiter write port (slave).
interface sdram_stream_writer_if;
  // byte stream from the SD-card readout
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  // write request to the arbiter
  logic        write_out;
  logic [25:0] addr_out;
  logic [15:0] wrdata_out;
  logic        ack_in;
  logic        sd_write_resume;

  modport master (
    input  byte_in, byte_valid, ack_in, sd_write_resume,
    output byte_ready, write_out, addr_out, wrdata_out
  );

  modport slave (
    output byte_in, byte_valid, ack_in, sd_write_resume,
    input  byte_ready, write_out, addr_out, wrdata_out
  );
endinterface

// File: rtl/sdram_stream_writer.sv
// SD-card stream writer: packs byte pairs into 16-bit words in a small FIFO
// and issues one-word write requests to the SDRAM arbiter. The 24-bit word
// space is split in two halves on addr bit 23; after filling a half the
// writer waits for the arbiter to report that playback changed halves.
module sdram_stream_writer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk50,
  input  logic                         reset_n,
  input  logic                         start,
  sdram_stream_writer_if.master        bus,
  output logic                         busy,
  output logic                         cur_half,
  output logic                         half_done
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, POP, WAIT_RESUME} state_t;

  state_t        state, state_nxt;
  logic [23:0]   addr_cnt;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          have_low;
  logic [7:0]    low_byte;
  logic          fifo_full, fifo_empty;
  logic          take, push, pop, restart, last_of_half;

  assign fifo_full    = (count == FULL_CNT);
  assign fifo_empty   = (count == '0);
  assign busy         = (state != IDLE);
  assign cur_half     = addr_cnt[23];
  assign restart      = (state == IDLE) && start;
  assign last_of_half = &addr_cnt[22:0];

  // A low byte is still taken when the FIFO is full; only the completing
  // high byte has to wait for room.
  assign bus.byte_ready = busy && !(fifo_full && have_low);
  assign take           = bus.byte_valid && bus.byte_ready;
  assign push           = take && have_low;
  assign pop            = (state == REQ) && !fifo_empty && bus.ack_in;

  assign bus.addr_out   = {2'b00, addr_cnt};
  // Head word only; an empty FIFO presents zero rather than stale storage.
  assign bus.wrdata_out = fifo_empty ? 16'h0000 : mem[rd_ptr];

  // State register
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and request outputs
  always_comb begin
    state_nxt     = state;
    bus.write_out = 1'b0;
    half_done     = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        bus.write_out = !fifo_empty;
        if (!fifo_empty && bus.ack_in) begin
          // The last word of a half parks the writer until playback moves on.
          if (last_of_half) begin
            half_done = 1'b1;
            state_nxt = WAIT_RESUME;
          end else begin
            state_nxt = POP;
          end
        end
      end
      // One dead cycle so the arbiter sees write drop between words.
      POP:         state_nxt = REQ;
      // A resume level seen on the ack edge itself is deliberately ignored.
      WAIT_RESUME: if (bus.sd_write_resume) state_nxt = REQ;
      default:     state_nxt = IDLE;
    endcase
  end

  // Byte pairing and FIFO pointers; a new stream discards everything queued
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      have_low <= 1'b0;
      low_byte <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (restart) begin
      have_low <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (take) begin
        if (!have_low) begin
          low_byte <= bus.byte_in;
          have_low <= 1'b1;
        end else begin
          have_low <= 1'b0;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Word storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk50) begin
    if (push) mem[wr_ptr] <= {bus.byte_in, low_byte};
  end

  // Word address advances on each acknowledged write, wrapping at 24 bits
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n)     addr_cnt <= 24'h000000;
    else if (restart) addr_cnt <= 24'h000000;
    else if (pop)     addr_cnt <= addr_cnt + 24'h000001;
  end
endmodule
